// File: rtl/inst_sequencer.sv
// Program-buffer instruction sequencer: loads a small instruction buffer, then issues
// entries in order over a valid/ready handshake until a halt word or the last entry.
module inst_sequencer #(
  parameter int          DEPTH   = 8,
  parameter logic [5:0]  HALT_OP = 6'b111111,
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic          abort,
  input  logic          step_mode,
  input  logic          step,
  input  logic          inst_ready,
  output logic          inst_valid,
  output logic [31:0]   inst_out,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [7:0]    issue_count
);

  // state    | meaning
  // IDLE     | waiting for start; buffer writable
  // FETCH    | reading mem[pc] into the issue register
  // ISSUE    | inst_valid high, waiting for inst_ready
  // STEPWAIT | single-step mode, waiting for a step pulse
  // DONE     | run finished (halt word or last entry issued); buffer writable
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_STEPWAIT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   mem_q [DEPTH];
  logic          mem_we;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          mem_we = load_en;
          if (start) begin
            pc_d    = '0;
            cnt_d   = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          inst_d  = mem_q[pc_q];
          state_d = (mem_q[pc_q][31:26] == HALT_OP) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: begin
          if (inst_ready) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            if (pc_q == LAST_PC) begin
              state_d = S_DONE;
            end else begin
              pc_d    = pc_q + AW'(1);
              state_d = step_mode ? S_STEPWAIT : S_FETCH;
            end
          end
        end
        S_STEPWAIT: begin
          if (step) state_d = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The buffer lives in flops so that reset can clear every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      if (mem_we) mem_q[load_addr] <= load_data;
    end
  end

  assign inst_valid  = (state_q == S_ISSUE);
  assign inst_out    = inst_q;
  assign pc          = pc_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_STEPWAIT);
  assign done        = (state_q == S_DONE);
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: each run pushes the expected issue stream
// from a program-level model; a monitor pops and compares on every handshake.
module tb_inst_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam logic [5:0] HALT = 6'b111111;

  logic          clk = 1'b0;
  logic          rst, load_en, start, abort, step_mode, step, inst_ready;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          inst_valid, busy, done;
  logic [31:0]   inst_out;
  logic [AW-1:0] pc;
  logic [7:0]    issue_count;

  always #5 clk = ~clk;

  inst_sequencer #(.DEPTH(DEPTH), .HALT_OP(HALT)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .abort(abort), .step_mode(step_mode), .step(step), .inst_ready(inst_ready),
    .inst_valid(inst_valid), .inst_out(inst_out), .pc(pc), .busy(busy), .done(done),
    .issue_count(issue_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int hs_seen = 0;
  bit rand_ready = 0;
  bit rand_step = 0;

  typedef struct { logic [31:0] word; int idx; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] model_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !abort && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", inst_out, 32'hDEAD_BEEF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("issue_word", inst_out, mon_e.word);
        chk("issue_pc", 32'(pc), 32'(mon_e.idx));
      end
      hs_seen++;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) #2 inst_ready = 1'($urandom_range(0, 1));
  end
  always @(posedge clk) begin
    if (rand_step) #2 step = ($urandom_range(0, 3) == 0);
  end

  // Run length = index of the first halt word, or the whole buffer.
  function automatic int model_len();
    for (int i = 0; i < DEPTH; i++)
      if (model_mem[i][31:26] == HALT) return i;
    return DEPTH;
  endfunction

  function automatic int model_final_pc();
    int n = model_len();
    return (n == DEPTH) ? DEPTH - 1 : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    load_en = 1'b1; load_addr = AW'(addr); load_data = data;
    tick();
    load_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic start_run();
    int n = model_len();
    for (int i = 0; i < n; i++) exp_q.push_back('{model_mem[i], i});
    hs_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin tick(); k++; end
    if (!done) begin
      chk("done_timeout", 32'(done), 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
    end
  endtask

  task automatic end_run(input int n, input int fpc);
    wait_done(600);
    chk("run_issue_count", 32'(issue_count), 32'(n));
    chk("run_final_pc", 32'(pc), 32'(fpc));
    chk("run_done", 32'(done), 32'd1);
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst_out"}, inst_out, 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_count"}, 32'(issue_count), 32'd0);
  endtask

  initial begin : main
    logic [31:0] w, hold_out;
    logic [AW-1:0] hold_pc;
    logic [7:0] hold_cnt;
    int n, fpc, k;
    rst = 1'b1; load_en = 0; load_addr = '0; load_data = '0; start = 0; abort = 0;
    step_mode = 0; step = 0; inst_ready = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Three-word program ending in a halt.
    load(0, 32'h9104_1000); load(1, 32'hB184_0800); load(2, 32'hFC00_0000);
    inst_ready = 1'b1;
    n = model_len(); fpc = model_final_pc();
    start_run();
    chk("lat_c1_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("lat_c2_valid", 32'(inst_valid), 32'd1);
    chk("lat_c2_word", inst_out, 32'h9104_1000);
    tick();
    chk("lat_c3_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("lat_c4_valid", 32'(inst_valid), 32'd1);
    end_run(n, fpc);

    // Full buffer of non-halt words: no wrap, nothing reissued after done.
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom; w[31:26] = 6'(i + 1);
      load(i, w);
    end
    n = model_len(); fpc = model_final_pc();
    start_run();
    end_run(n, fpc);
    repeat (6) tick();
    chk("no_reissue_after_done", 32'(hs_seen), 32'(n));

    // Back-pressure, then abort in ISSUE.
    inst_ready = 1'b0;
    start_run();
    tick();
    hold_out = inst_out; hold_pc = pc; hold_cnt = issue_count;
    chk("stall_word", inst_out, model_mem[0]);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst_out", inst_out, hold_out);
      chk("stall_pc", 32'(pc), 32'(hold_pc));
      chk("stall_count", 32'(issue_count), 32'(hold_cnt));
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();
    chk("stall_one_handshake", 32'(issue_count), 32'd1);
    chk("stall_second_valid", 32'(inst_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(inst_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pc_hold", 32'(pc), 32'd1);
    chk("abort_count_hold", 32'(issue_count), 32'd1);
    exp_q.delete();
    rand_ready = 1;
    n = model_len(); fpc = model_final_pc();
    start_run();
    end_run(n, fpc);
    rand_ready = 0; inst_ready = 1'b1;

    // Single-step: four issues, halt at entry 4.
    load(4, {HALT, 26'h0});
    n = model_len(); fpc = model_final_pc();
    step_mode = 1'b1;
    start_run();
    tick(); tick();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 10; c++) begin
        chk("stepwait_busy", 32'(busy), 32'd1);
        chk("stepwait_valid", 32'(inst_valid), 32'd0);
        chk("stepwait_count", 32'(issue_count), 32'(p + 1));
        tick();
      end
      step = 1'b1; tick(); step = 1'b0;
      tick(); tick();
    end
    chk("step_before_halt_busy", 32'(busy), 32'd1);
    step = 1'b1; tick(); step = 1'b0;
    end_run(n, fpc);
    step_mode = 1'b0;

    // Randomized programs with ignored loads/starts during the run.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w = $urandom;
        if ($urandom_range(0, 4) == 0) w[31:26] = HALT;
        else if (w[31:26] == HALT) w[31:26] = 6'h00;
        load(i, w);
      end
      n = model_len(); fpc = model_final_pc();
      rand_ready = 1; rand_step = 1;
      step_mode = 1'($urandom_range(0, 1));
      start_run();
      k = 0;
      while (!done && k < 600) begin
        step_mode = 1'($urandom_range(0, 1));
        load_en   = busy & 1'($urandom_range(0, 1));
        load_addr = AW'($urandom_range(0, DEPTH - 1));
        load_data = $urandom;
        start     = busy & 1'($urandom_range(0, 1));
        tick(); k++;
      end
      load_en = 0; start = 0;
      rand_ready = 0; rand_step = 0;
      #3; step = 0; inst_ready = 0;
      end_run(n, fpc);
    end

    // Reset mid-run after three issues, then run an all-zero buffer.
    for (int i = 0; i < DEPTH; i++) load(i, 32'h0400_0000 + 32'(i));
    inst_ready = 1'b1; step_mode = 1'b0;
    start_run();
    k = 0;
    while (hs_seen < 3 && k < 100) begin tick(); k++; end
    tick();
    chk("pre_reset_count", 32'(issue_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrun_reset");
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    n = model_len(); fpc = model_final_pc();
    start_run();
    tick();
    chk("zero_word_valid", 32'(inst_valid), 32'd1);
    end_run(n, fpc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
